// File: rtl/capture_ram_arbiter_if.sv
// Signal bundle between the capture/arbiter core and its environment.
// The slave side is the core, and the master side is the surrounding logic and the RAM.
interface capture_ram_arbiter_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 8
);
    logic          start;
    logic          abort;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          nios_req;
    logic          gui_req;
    logic [AW-1:0] nios_addr;
    logic [AW-1:0] gui_addr;
    logic          nios_gnt;
    logic          gui_gnt;
    logic          nios_rvalid;
    logic          gui_rvalid;
    logic [DW-1:0] nios_rdata;
    logic [DW-1:0] gui_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren;
    logic [DW-1:0] ram_q;
    logic          busy;
    logic          done;
    logic [AW:0]   sample_count;

    modport master (
        output start, abort, sample_valid, sample_data,
        output nios_req, gui_req, nios_addr, gui_addr, ram_q,
        input  nios_gnt, gui_gnt, nios_rvalid, gui_rvalid, nios_rdata, gui_rdata,
        input  ram_addr, ram_wdata, ram_wren, busy, done, sample_count
    );

    modport slave (
        input  start, abort, sample_valid, sample_data,
        input  nios_req, gui_req, nios_addr, gui_addr, ram_q,
        output nios_gnt, gui_gnt, nios_rvalid, gui_rvalid, nios_rdata, gui_rdata,
        output ram_addr, ram_wdata, ram_wren, busy, done, sample_count
    );
endinterface

// File: rtl/capture_ram_arbiter.sv
// Sample capture into a single-port RAM, with round-robin read arbitration for the Nios and GUI
// readers. The RAM is shared between capture writes and the two readers.
module capture_ram_arbiter #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 8
) (
    input logic                   clk,
    input logic                   reset,
    capture_ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StCapture, StDone} stateType;

    stateType      state;
    logic [AW:0]   sampleCount;
    logic [AW:0]   countNext;
    logic [AW-1:0] addrQ;
    logic [DW-1:0] wdataQ;
    logic          lastWasGui;
    logic          niosGntD1, guiGntD1;
    logic          niosRvalid, guiRvalid;
    logic [DW-1:0] niosRdata, guiRdata;
    logic          wrEn, arbOpen, niosCan, guiCan, niosGnt, guiGnt;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramWdata;

    assign countNext = sampleCount + {{AW{1'b0}}, 1'b1};
    assign wrEn      = (state == StCapture) && bus.sample_valid && !bus.abort;

    // Grants are combinational so a lone requester is served in the cycle it asks; a port
    // granted last cycle sits out one cycle, and gating with reset keeps grants low in reset.
    assign arbOpen = (state != StCapture) && !reset;
    assign niosCan = bus.nios_req && !niosGntD1 && arbOpen;
    assign guiCan  = bus.gui_req && !guiGntD1 && arbOpen;
    assign niosGnt = niosCan && (!guiCan || lastWasGui);
    assign guiGnt  = guiCan && !niosGnt;

    always_comb begin
        ramAddr = addrQ;
        if (wrEn) begin
            ramAddr = sampleCount[AW-1:0];
        end else if (niosGnt) begin
            ramAddr = bus.nios_addr;
        end else if (guiGnt) begin
            ramAddr = bus.gui_addr;
        end
        ramWdata = wrEn ? bus.sample_data : wdataQ;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            sampleCount <= '0;
            addrQ       <= '0;
            wdataQ      <= '0;
            lastWasGui  <= 1'b1;
            niosGntD1   <= 1'b0;
            guiGntD1    <= 1'b0;
            niosRvalid  <= 1'b0;
            guiRvalid   <= 1'b0;
            niosRdata   <= '0;
            guiRdata    <= '0;
        end else begin
            addrQ      <= ramAddr;
            wdataQ     <= ramWdata;
            niosGntD1  <= niosGnt;
            guiGntD1   <= guiGnt;
            niosRvalid <= niosGntD1;
            guiRvalid  <= guiGntD1;
            // ram_q carries the granted word one cycle after the grant.
            if (niosGntD1) niosRdata <= bus.ram_q;
            if (guiGntD1)  guiRdata  <= bus.ram_q;
            if (niosGnt) begin
                lastWasGui <= 1'b0;
            end else if (guiGnt) begin
                lastWasGui <= 1'b1;
            end
            case (state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state       <= StCapture;
                        sampleCount <= '0;
                    end
                end
                StCapture: begin
                    if (bus.abort) begin
                        state <= StIdle;
                    end else if (bus.sample_valid) begin
                        sampleCount <= countNext;
                        if (countNext[AW]) state <= StDone;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.nios_gnt     = niosGnt;
    assign bus.gui_gnt      = guiGnt;
    assign bus.nios_rvalid  = niosRvalid;
    assign bus.gui_rvalid   = guiRvalid;
    assign bus.nios_rdata   = niosRdata;
    assign bus.gui_rdata    = guiRdata;
    assign bus.ram_addr     = ramAddr;
    assign bus.ram_wdata    = ramWdata;
    assign bus.ram_wren     = wrEn;
    assign bus.busy         = (state == StCapture);
    assign bus.done         = (state == StDone);
    assign bus.sample_count = sampleCount;
endmodule

// File: doc/capture_ram_arbiter.md
CAPTURE_RAM_ARBITER -- requirements
Module: capture_ram_arbiter

Interface
REQ-001 Parameter AW, 12, RAM address width; capture depth is 2^AW words.
REQ-002 Parameter DW, 8, sample and RAM data width.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces all state to reset values immediately.
REQ-005 start  in  1  one-cycle pulse; arms a capture.
REQ-006 abort  in  1  one-cycle pulse; terminates a capture in progress.
REQ-007 sample_valid  in  1  one-cycle strobe; sample_data is valid this cycle.
REQ-008 sample_data  in  DW  sample to store.
REQ-009 nios_req / gui_req  in  1 each  read request; held high until granted.
REQ-010 nios_addr / gui_addr  in  AW each  read address; held stable while req is high.
REQ-011 nios_gnt / gui_gnt  out  1 each  one-cycle grant; the request is consumed this cycle.
REQ-012 nios_rvalid / gui_rvalid  out  1 each  one-cycle strobe; rdata is valid this cycle.
REQ-013 nios_rdata / gui_rdata  out  DW each  read data; held until that port's next rvalid.
REQ-014 ram_addr  out  AW  single-port RAM address.
REQ-015 ram_wdata  out  DW  RAM write data.
REQ-016 ram_wren  out  1  RAM write enable.
REQ-017 ram_q  in  DW  RAM read data; valid one cycle after the address is presented.
REQ-018 busy  out  1  high in CAPTURE.
REQ-019 done  out  1  high in DONE.
REQ-020 sample_count  out  AW+1  number of samples written in the current or last capture.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, CAPTURE and DONE.
REQ-022 The FSM SHALL make these transitions:
- IDLE: start moves to CAPTURE and clears sample_count to 0.
- CAPTURE: abort moves to IDLE with sample_count retained.
- CAPTURE: the write that makes sample_count reach 2^AW moves to DONE.
- DONE: start moves to CAPTURE and clears sample_count to 0.
REQ-023 In CAPTURE, each sample_valid SHALL write sample_data to address sample_count[AW-1:0] in the same cycle (ram_wren=1) and increment sample_count by 1.
REQ-024 In CAPTURE with sample_valid low, ram_wren SHALL be 0.
REQ-025 sample_valid in IDLE or DONE SHALL be ignored; no write occurs and sample_count does not change.
REQ-026 start while in CAPTURE SHALL be ignored.
REQ-027 abort outside CAPTURE SHALL be ignored.
REQ-028 If abort and sample_valid occur in the same cycle, abort SHALL win and no write SHALL occur.
REQ-029 If start and sample_valid occur in the same cycle in IDLE or DONE, the sample SHALL NOT be written.
REQ-030 No read grant SHALL be issued in CAPTURE; pending requests SHALL stall without loss.
REQ-031 In IDLE or DONE, at most one grant SHALL be issued per cycle, and ram_addr SHALL equal the granted port's address in the grant cycle.
REQ-032 Arbitration SHALL be round-robin when both ports request: the port not granted most recently wins.
- After reset, Nios has priority.
- A lone requester is granted immediately.
REQ-033 The granted port's rvalid SHALL assert exactly 2 cycles after its grant, with rdata equal to the RAM word at the granted address.
REQ-034 A port SHALL receive at most one grant per 2 cycles, so a requester holding req continuously sees gnt on alternate cycles.
REQ-035 When no access occurs, ram_addr SHALL hold its previous value and ram_wren SHALL be 0.
REQ-036 A grant issued in the cycle before a CAPTURE entry SHALL still complete its rvalid, even though a write may overlap the read pipeline.
REQ-037 The done output SHALL be high throughout DONE and low in all other states.
REQ-038 The busy output SHALL be high throughout CAPTURE and low in all other states.

Reset
REQ-039 On reset the block SHALL enter IDLE and drive:
- sample_count=0
- busy=0, done=0
- all gnt=0, all rvalid=0, all rdata=0
- ram_addr=0, ram_wdata=0, ram_wren=0
- round-robin pointer set to favour Nios
REQ-040 Reset asserted mid-capture or mid-read SHALL abandon the operation; no rvalid SHALL follow the deassertion of reset.

Verification
REQ-041 Full capture, AW=4: start, then 16 sample_valid with data 0x10..0x1F -> addresses 0..15 written; done=1 after the 16th write; sample_count=16; a 17th sample_valid produces no write.
REQ-042 Abort: start, 5 samples, abort coincident with the 6th sample_valid -> only 5 writes; state IDLE; sample_count=5; done=0.
REQ-043 Contention: in DONE, nios_req (addr 3) and gui_req (addr 7) held high together -> grants alternate Nios, GUI, Nios, GUI; each rvalid arrives 2 cycles after its grant with the data written at addresses 3 and 7.
REQ-044 Stall: gui_req raised during CAPTURE -> no gui_gnt until DONE; gui_gnt in the first DONE cycle; gui_rvalid 2 cycles later.
REQ-045 Asynchronous reset: reset pulsed with no clock edge, between a grant and its rvalid -> all outputs at reset values immediately; no rvalid after release.
REQ-046 Re-arm: start in DONE -> done=0, busy=1, sample_count=0; the next sample is written to address 0.
